// File: rtl/rf_update_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rf_update_arbiter                                                      |
// | One-update-per-cycle sequencer for the regfile/dependency table:       |
// | rename requests vs. buffered ROB commit broadcasts, with anti-starve.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module rf_update_arbiter #(
  parameter int TAG_W        = 4,
  parameter int DATA_W       = 32,
  parameter int CQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            rdy_in,
  input  logic                            iss_valid,
  output logic                            iss_ready,
  input  logic [4:0]                      iss_rd,
  input  logic [TAG_W-1:0]                iss_tag,
  input  logic                            cmt_valid,
  output logic                            cmt_ready,
  input  logic [TAG_W-1:0]                cmt_tag,
  input  logic [DATA_W-1:0]               cmt_data,
  output logic                            rf_mode,
  output logic [4:0]                      rf_rd,
  output logic [TAG_W-1:0]                rf_foq_depend,
  output logic [DATA_W-1:0]               rf_rob_data,
  output logic [TAG_W-1:0]                rf_rob_depend,
  output logic [$clog2(CQ_DEPTH+1)-1:0]   cq_count
);

  localparam int PTR_W = $clog2(CQ_DEPTH);
  localparam int CNT_W = $clog2(CQ_DEPTH + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(CQ_DEPTH);
  localparam logic [SC_W-1:0]  STARVE_C = SC_W'(STARVE_LIMIT);

  logic [TAG_W-1:0]  tag_mem_q  [CQ_DEPTH];
  logic [DATA_W-1:0] data_mem_q [CQ_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SC_W-1:0]   starve_q, starve_d;

  logic              mode_q, mode_d;
  logic [4:0]        rd_q, rd_d;
  logic [TAG_W-1:0]  foq_q, foq_d;
  logic [DATA_W-1:0] rob_data_q, rob_data_d;
  logic [TAG_W-1:0]  rob_dep_q, rob_dep_d;

  logic w_empty, w_full, w_iss_req, w_force, w_grant_iss, w_grant_cmt, w_push;

  always_comb begin
    w_empty     = (count_q == '0);
    w_full      = (count_q == DEPTH_C);
    w_iss_req   = iss_valid && (iss_rd != 5'd0);
    w_force     = w_iss_req && (starve_q == STARVE_C);
    w_grant_iss = rdy_in && w_iss_req && (w_empty || w_force);
    w_grant_cmt = rdy_in && !w_empty && !w_grant_iss;
    cmt_ready   = rdy_in && !w_full;
    // Tag 0 means "no producer": accept it but never occupy a slot.
    w_push      = cmt_valid && cmt_ready && (cmt_tag != '0);
    iss_ready   = rdy_in && iss_valid && ((iss_rd == 5'd0) || w_grant_iss);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    starve_d   = starve_q;
    mode_d     = mode_q;
    rd_d       = rd_q;
    foq_d      = foq_q;
    rob_data_d = rob_data_q;
    rob_dep_d  = rob_dep_q;
    if (rdy_in) begin
      if (w_push)      wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_grant_cmt) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(w_push) - CNT_W'(w_grant_cmt);

      if (w_grant_iss)
        starve_d = '0;
      else if (w_grant_cmt && w_iss_req && (starve_q != STARVE_C))
        starve_d = starve_q + 1'b1;

      // Every ready cycle overwrites the presented update; idle is all zero.
      mode_d     = 1'b0;
      rd_d       = 5'd0;
      foq_d      = '0;
      rob_data_d = '0;
      rob_dep_d  = '0;
      if (w_grant_iss) begin
        rd_d  = iss_rd;
        foq_d = iss_tag;
      end else if (w_grant_cmt) begin
        mode_d     = 1'b1;
        rob_data_d = data_mem_q[rd_ptr_q];
        rob_dep_d  = tag_mem_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      mode_q     <= 1'b0;
      rd_q       <= 5'd0;
      foq_q      <= '0;
      rob_data_q <= '0;
      rob_dep_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      mode_q     <= mode_d;
      rd_q       <= rd_d;
      foq_q      <= foq_d;
      rob_data_q <= rob_data_d;
      rob_dep_q  <= rob_dep_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      tag_mem_q[wr_ptr_q]  <= cmt_tag;
      data_mem_q[wr_ptr_q] <= cmt_data;
    end
  end

  assign rf_mode       = mode_q;
  assign rf_rd         = rd_q;
  assign rf_foq_depend = foq_q;
  assign rf_rob_data   = rob_data_q;
  assign rf_rob_depend = rob_dep_q;
  assign cq_count      = count_q;

endmodule
`default_nettype wire

// File: doc/rf_update_arbiter.md
Name: rf_update_arbiter

Overview:
Sequences all writes into the register-file/dependency-table block, which accepts exactly one update per cycle: either a rename (mode 0: rd gets tag) or a ROB broadcast (mode 1: every entry waiting on tag gets data).
Arbitrates between the instruction-issue path (rename requests) and the ROB commit path (result broadcasts). Commits are buffered in a small FIFO so the ROB never stalls on a rename cycle. A starvation counter guarantees issue forward progress.

Parameters:
TAG_W, 4, ROB tag width; tag 0 = None
DATA_W, 32, result data width
CQ_DEPTH, 4, commit FIFO entries (power of 2)
STARVE_LIMIT, 3, consecutive denied issue cycles before issue gets forced priority

Ports:
clk_in  in  1  clock
rst_in  in  1  reset: synchronous, active-high
rdy_in  in  1  global ready; low = pause
iss_valid  in  1  rename request valid
iss_ready  out  1  rename request accepted this cycle (combinational)
iss_rd  in  5  destination register
iss_tag  in  TAG_W  ROB tag assigned to iss_rd
cmt_valid  in  1  commit broadcast valid
cmt_ready  out  1  commit FIFO can accept
cmt_tag  in  TAG_W  committing ROB tag
cmt_data  in  DATA_W  committed result
rf_mode  out  1  0 rename / 1 ROB update (registered)
rf_rd  out  5  rename destination (registered)
rf_foq_depend  out  TAG_W  rename tag (registered)
rf_rob_data  out  DATA_W  broadcast data (registered)
rf_rob_depend  out  TAG_W  broadcast tag (registered)
cq_count  out  3  commit FIFO occupancy, width clog2(CQ_DEPTH+1)

Behaviour:
- Reset: FIFO empty, cq_count=0, starve_cnt=0. All rf_* outputs are 0, which is the idle encoding (mode 0 with rd 0 is a no-op in the regfile).
- rdy_in low: no state change, iss_ready=0, cmt_ready=0. rf_* outputs hold their value so the pending update applies when rdy_in returns.
- The remaining rules apply only in cycles with rdy_in high.
- cmt_ready = (cq_count < CQ_DEPTH). No push when full, even if a pop occurs in the same cycle.
- Commit push: cmt_valid && cmt_ready. An entry with cmt_tag == 0 is accepted and discarded, never enqueued.
- Arbitration each cycle:
  - Candidates are the FIFO head (if non-empty) and the issue request (iss_valid && iss_rd != 0).
  - Default priority is commit.
  - If starve_cnt == STARVE_LIMIT and issue is valid, issue wins.
- Winner issue: iss_ready=1. Next cycle rf_mode=0, rf_rd=iss_rd, rf_foq_depend=iss_tag. starve_cnt is cleared.
- Winner commit: pop the head. Next cycle rf_mode=1, rf_rob_depend=tag, rf_rob_data=data. If issue was valid and lost, starve_cnt increments, saturating at STARVE_LIMIT.
- No winner: next cycle rf_* = idle (all 0). Every rdy cycle overwrites rf_*; an update is presented for exactly one rdy cycle.
- iss_rd == 0: iss_ready=1 immediately. No regfile update, no arbitration slot used, starve_cnt unchanged.
- No bypass: a commit pushed in cycle N is at the earliest popped in N+1 and presented on rf_* in N+2. Issue granted in N is presented in N+1.
- FIFO preserves commit order, duplicate tags included. Pointers wrap modulo CQ_DEPTH.
- Simultaneous push and pop (not full): occupancy unchanged; the pushed entry goes to the tail.
- Reset mid-operation discards FIFO contents and any presented update; rf_* go idle the next cycle.
- Unused rf_* fields are driven 0: rf_rob_* during a rename, rf_rd/rf_foq_depend during a broadcast.

Test Plan:
1. Reset then iss_valid, rd=5, tag=3, FIFO empty -> iss_ready=1 same cycle; next cycle rf_mode=0, rf_rd=5, rf_foq_depend=3; following cycle rf_* all 0.
2. Commit tag=3, data=0xDEADBEEF at cycle N, no issue -> cq_count=1 at N+1; at N+2 rf_mode=1, rf_rob_depend=3, rf_rob_data=0xDEADBEEF; cq_count=0.
3. FIFO holds 4 commits and iss_valid held (rd=7) -> 3 commits presented, then the issue is forced on the 4th arbitration cycle (iss_ready=1), then the last commit. starve_cnt returns to 0.
4. Push 5 commits back-to-back with issue idle -> the 5th sees cmt_ready=0 only while cq_count==4. All 5 are presented in push order, none lost.
5. Present an issue update, then drop rdy_in for 3 cycles -> rf_* hold, iss_ready=0, cmt_ready=0, cq_count frozen. Update still visible in the first rdy cycle after.
6. cmt_tag=0 pushed, and iss_valid with rd=0 -> both accepted, cq_count stays 0, rf_* stay idle, starve_cnt unchanged.
